// File: rtl/pq_ctrl.sv
// Front-end controller for the priority-queue cell array: arbitrates push/pop/drop
// requests, rejects illegal ones, and sequences one array command at a time.
module pq_ctrl #(
  parameter int IW    = 4,
  parameter int PW    = 4,
  parameter int DEPTH = 8,
  parameter int TMO   = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_req_i,
  input  logic [IW-1:0]                push_id_i,
  input  logic [PW-1:0]                push_prio_i,
  output logic                         push_ack_o,
  input  logic                         pop_req_i,
  output logic                         pop_ack_o,
  output logic [IW-1:0]                pop_id_o,
  output logic [PW-1:0]                pop_prio_o,
  input  logic                         drop_req_i,
  input  logic [IW-1:0]                drop_id_i,
  output logic                         drop_ack_o,
  output logic                         err_o,
  output logic                         arr_push_o,
  output logic                         arr_pop_o,
  output logic                         arr_drop_o,
  output logic [IW-1:0]                arr_id_o,
  output logic [PW-1:0]                arr_prio_o,
  input  logic                         arr_push_vld_i,
  input  logic                         arr_pop_vld_i,
  input  logic                         arr_drop_vld_i,
  input  logic [IW-1:0]                arr_head_id_i,
  input  logic [PW-1:0]                arr_head_prio_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int TW  = $clog2(TMO+1);
  localparam int NID = 1 << IW;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_DROP} op_t;

  state_t          r_state;
  op_t             r_op;
  logic [IW-1:0]   r_id;
  logic [PW-1:0]   r_prio;
  logic [TW-1:0]   r_tmo;
  logic [CW-1:0]   r_count;
  logic [NID-1:0]  r_present;
  logic            r_push_ack, r_pop_ack, r_drop_ack, r_err;
  logic            r_arr_push, r_arr_pop, r_arr_drop;
  logic [IW-1:0]   r_arr_id, r_pop_id;
  logic [PW-1:0]   r_arr_prio, r_pop_prio;

  logic            w_full, w_empty, w_hit, w_illegal, w_done, w_tmo_hit;
  logic            w_is_push, w_is_pop, w_is_drop;
  logic [TW-1:0]   w_tmo_nxt;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_hit     = r_present[r_id];
  assign w_is_push = (r_op == OP_PUSH);
  assign w_is_pop  = (r_op == OP_POP);
  assign w_is_drop = (r_op == OP_DROP);
  assign w_tmo_nxt = r_tmo + TW'(1);
  assign w_tmo_hit = (w_tmo_nxt == TW'(TMO));

  always_comb begin
    w_illegal = 1'b0;
    w_done    = 1'b0;
    case (r_op)
      OP_PUSH: begin
        w_illegal = w_full || (r_id == '0) || w_hit;
        w_done    = arr_push_vld_i;
      end
      OP_POP: begin
        w_illegal = w_empty;
        w_done    = arr_pop_vld_i;
      end
      default: begin
        w_illegal = (r_id == '0) || !w_hit;
        w_done    = arr_drop_vld_i;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_present  <= '0;
      r_tmo      <= '0;
      r_push_ack <= 1'b0;
      r_pop_ack  <= 1'b0;
      r_drop_ack <= 1'b0;
      r_err      <= 1'b0;
      r_arr_push <= 1'b0;
      r_arr_pop  <= 1'b0;
      r_arr_drop <= 1'b0;
      r_arr_id   <= '0;
      r_arr_prio <= '0;
      r_pop_id   <= '0;
      r_pop_prio <= '0;
    end else begin
      r_push_ack <= 1'b0;
      r_pop_ack  <= 1'b0;
      r_drop_ack <= 1'b0;
      r_err      <= 1'b0;
      r_arr_push <= 1'b0;
      r_arr_pop  <= 1'b0;
      r_arr_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (drop_req_i) begin
            r_op    <= OP_DROP;
            r_id    <= drop_id_i;
            r_prio  <= '0;
            r_state <= S_CHECK;
          end else if (pop_req_i) begin
            r_op    <= OP_POP;
            r_id    <= '0;
            r_prio  <= '0;
            r_state <= S_CHECK;
          end else if (push_req_i) begin
            r_op    <= OP_PUSH;
            r_id    <= push_id_i;
            r_prio  <= push_prio_i;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_illegal) begin
            r_push_ack <= w_is_push;
            r_pop_ack  <= w_is_pop;
            r_drop_ack <= w_is_drop;
            r_err      <= 1'b1;
            if (w_is_pop) begin
              r_pop_id   <= '0;
              r_pop_prio <= '0;
            end
            r_state <= S_RESP;
          end else begin
            r_arr_push <= w_is_push;
            r_arr_pop  <= w_is_pop;
            r_arr_drop <= w_is_drop;
            r_arr_id   <= r_id;
            r_arr_prio <= r_prio;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes precedence over a timeout landing in the same cycle.
          if (w_done || w_tmo_hit) begin
            r_push_ack <= w_is_push;
            r_pop_ack  <= w_is_pop;
            r_drop_ack <= w_is_drop;
            r_err      <= !w_done;
            r_arr_id   <= '0;
            r_arr_prio <= '0;
            r_state    <= S_RESP;
            if (w_done) begin
              if (w_is_push) begin
                r_present[r_id] <= 1'b1;
                r_count         <= r_count + CW'(1);
              end else if (w_is_pop) begin
                r_pop_id                 <= arr_head_id_i;
                r_pop_prio               <= arr_head_prio_i;
                r_present[arr_head_id_i] <= 1'b0;
                r_count                  <= r_count - CW'(1);
              end else begin
                r_present[r_id] <= 1'b0;
                r_count         <= r_count - CW'(1);
              end
            end else if (w_is_pop) begin
              r_pop_id   <= '0;
              r_pop_prio <= '0;
            end
          end else begin
            r_tmo <= w_tmo_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign push_ack_o = r_push_ack;
  assign pop_ack_o  = r_pop_ack;
  assign drop_ack_o = r_drop_ack;
  assign err_o      = r_err;
  assign arr_push_o = r_arr_push;
  assign arr_pop_o  = r_arr_pop;
  assign arr_drop_o = r_arr_drop;
  assign arr_id_o   = r_arr_id;
  assign arr_prio_o = r_arr_prio;
  assign pop_id_o   = r_pop_id;
  assign pop_prio_o = r_pop_prio;
  assign count_o    = r_count;
  assign full_o     = w_full;
  assign empty_o    = w_empty;

endmodule

// File: doc/pq_ctrl.md
Name: pq_ctrl

Overview:
Front-end controller directly upstream of the priority-queue cell array. It accepts push, pop and drop requests from the interrupt/scheduler side through req/ack handshakes and arbitrates among them. It sequences exactly one command at a time into the head cell of the array and waits for that cell's completion strobe. It also keeps an ID-presence bitmap and an occupancy count, so illegal operations are rejected before they reach the array.

Parameters:
IW, 4, ID width; ID 0 is reserved and means "empty".
PW, 4, priority width.
DEPTH, 8, number of cells in the array (capacity).
TMO, 15, maximum cycles to wait for array completion before flagging an error.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
push_req_i  in  1  push request, held high until push_ack_o
push_id_i  in  IW  ID to insert
push_prio_i  in  PW  priority of ID
push_ack_o  out  1  one-cycle push completion
pop_req_i  in  1  pop request, held until pop_ack_o
pop_ack_o  out  1  one-cycle pop completion
pop_id_o  out  IW  popped ID, valid with pop_ack_o
pop_prio_o  out  PW  popped priority, valid with pop_ack_o
drop_req_i  in  1  drop request, held until drop_ack_o
drop_id_i  in  IW  ID to remove
drop_ack_o  out  1  one-cycle drop completion
err_o  out  1  error qualifier, valid with any ack
arr_push_o  out  1  push pulse to array head
arr_pop_o  out  1  pop pulse to array head
arr_drop_o  out  1  drop pulse to array head
arr_id_o  out  IW  push ID, or drop ID, to array
arr_prio_o  out  PW  push priority to array
arr_push_vld_i  in  1  array push completion
arr_pop_vld_i  in  1  array pop completion
arr_drop_vld_i  in  1  array drop completion
arr_head_id_i  in  IW  head cell ID
arr_head_prio_i  in  PW  head cell priority
count_o  out  $clog2(DEPTH+1)  occupancy
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0

Behaviour:
- Reset (rst_i high at a posedge): state IDLE; count 0; presence bitmap cleared; timeout counter 0. All ack/err/arr_* outputs 0; pop_id_o/pop_prio_o 0; empty_o 1; full_o 0.
- Reset mid-operation aborts the operation: no ack is issued, and the array is reset by the same rst_i.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE: if any request is high, latch the winner plus its operands, then go to CHECK.
  - Fixed priority: drop > pop > push.
  - Losers stay pending; they are not lost, because requests are level-held.
- CHECK: evaluate legality and set the latched error bit.
  - Push is illegal if full, if id==0, or if the ID is already present.
  - Pop is illegal if empty.
  - Drop is illegal if id==0 or the ID is not present.
  - Illegal operation: go to RESP with error and issue no array command.
  - Legal operation: go to ISSUE.
- ISSUE: assert exactly one of arr_push_o/arr_pop_o/arr_drop_o for one cycle, with arr_id_o/arr_prio_o driven from latched operands. Clear the timeout counter, then go to WAIT.
- arr_id_o/arr_prio_o hold the latched values from ISSUE through the end of WAIT; they are 0 otherwise.
- WAIT: wait for the completion strobe matching the latched op; other strobes are ignored. The timeout counter increments each cycle.
  - On push completion: set the ID bit and count+1.
  - On pop completion: capture arr_head_id_i/arr_head_prio_i into pop_id_o/pop_prio_o, clear that ID's bit, and count-1.
  - On drop completion: clear the drop ID bit and count-1.
  - Completion and timeout in the same cycle: completion wins.
  - Completion: go to RESP with no error.
  - Counter == TMO without completion: go to RESP with error; the bitmap and count are left unchanged.
- RESP: assert the matching ack_o for one cycle, with err_o = latched error bit; then go to IDLE.
- Timing: minimum legal latency from req seen in IDLE to ack is 5 cycles (IDLE→CHECK→ISSUE→WAIT(1)→RESP). Illegal op latency to ack is 3 cycles.
- Requester rule: a request must be deasserted, or re-presented as a new request, in the cycle after ack. The controller re-samples only in IDLE, so back-to-back operations are separated by at least one IDLE cycle.
- pop_id_o/pop_prio_o keep their last value until the next pop completion; an errored pop drives 0.
- count_o never wraps: legality checks guarantee it stays in 0..DEPTH. empty_o and full_o are derived combinationally from count.

Test Plan:
- Reset → all outputs 0, empty_o=1. Push id=3 prio=5 → arr_push_o pulse in 3rd cycle; after arr_push_vld_i, push_ack_o with err_o=0 and count_o=1.
- Push id=3 again → push_ack_o err_o=1, no arr_push_o, count_o stays 1. Push id=0 → err_o=1.
- Fill to DEPTH=8 with IDs 1..8 → full_o=1. Push id=9 → err_o=1, count_o=8.
- Pop with head 7/prio 12 → pop_ack_o, pop_id_o=7, pop_prio_o=12, count-1. Pop when empty → err_o=1, pop_id_o=0, no arr_pop_o.
- Drop, pop and push all asserted in the same cycle → serviced drop, then pop, then push, with an IDLE gap between each. Drop of absent id 9 → err_o=1.
- Array never returns arr_drop_vld_i → drop_ack_o with err_o=1 after TMO=15 WAIT cycles. Assert rst_i during WAIT → no ack, count_o=0.
